rotation_aligner: RTL and testbench
===================================

# rotation_aligner

Sequential stage directly upstream of `barrel_shifter`. Input words arrive with a fixed but unknown cyclic bit rotation. The block hunts for a rotation-unique sync word at frame boundaries, then locks the rotation amount after repeated confirmation. It forwards payload words, each paired with the locked `sh_amt`, so that the downstream rotate-right restores the original byte.

## Interface
- `SYNC_WORD`, default 8'hA5: frame sync byte; all 8 rotations must be distinct (8'hA5 satisfies this).
- `FRAME_LEN`, default 16: words per frame including the sync word; range 2..256.
- `LOCK_COUNT`, default 3: consecutive sync hits needed to lock; ≥1.
- `UNLOCK_COUNT`, default 4: consecutive sync misses, while locked, needed to drop lock; ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block accepts word this cycle.
- `in_data`  in  8  rotated input word.
- `out_valid`  out  1  payload word valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  8  payload word, still rotated; connects to `barrel_shifter.in`.
- `sh_amt`  out  3  rotate-right amount; connects to `barrel_shifter.sh_amt`.
- `locked`  out  1  high in LOCKED.
- `sync_hit`  out  1  one-cycle pulse on every accepted word recognised as sync.

## Operation
- Rotation convention: rotr(x,k) = {x[k-1:0], x[7:k]}. Candidate k is valid when rotr(in_data,k) == SYNC_WORD.
- Frame index `fidx`, width $clog2(FRAME_LEN), advances only on an accepted word and wraps FRAME_LEN-1 → 0. Index 0 is the sync slot.
- States:
  - HUNT: every accepted word is tested against all 8 rotations. On a match, latch k_cand, set hit_cnt=1 and fidx=1, pulse `sync_hit`, then go to VERIFY (or straight to LOCKED when LOCK_COUNT==1). Nothing is forwarded.
  - VERIFY: at fidx==0, test rotr(in_data,k_cand)==SYNC_WORD. On a hit, increment hit_cnt; when it reaches LOCK_COUNT, go to LOCKED and copy k_cand into the lock register. On a miss, go to HUNT, and that same word is not re-tested. Non-sync-slot words are dropped.
  - LOCKED: words at fidx≠0 are forwarded with `sh_amt`=k_lock. At fidx==0, the sync slot is never forwarded:
    - Hit: clear miss_cnt.
    - Miss: increment miss_cnt. When it reaches UNLOCK_COUNT, go to HUNT.
- `sh_amt` output is registered together with `out_data`, so it is constant for each held word.
- Lock loss does not flush a word already held in the output register; that word completes with its captured `sh_amt`.

## Timing
- Reset values:
  - Outputs: `out_valid`=0, `out_data`=0, `sh_amt`=0, `locked`=0, `sync_hit`=0, `in_ready`=1.
  - Internal: state=HUNT, fidx=0, all counters 0.
- `in_ready` = !out_valid || out_ready, combinational. Words are accepted when in_valid && in_ready, and only accepted words affect state or counters.
- Latency: an accepted payload word appears on `out_data`/`out_valid` the next cycle.
- Output register:
  - Loads on accept-and-forward.
  - Clears `out_valid` on out_ready && !load.
  - When out_ready and a new load coincide, the new word replaces the old one with no bubble, giving full throughput.
- `locked` and `sync_hit` are registered and update one cycle after the deciding word is accepted.
- `rst` mid-operation: state returns to reset values on the next edge, and any held output word is discarded.

## Structure
- `rotation_aligner_pkg` contains:
  - typedef enum state_t {HUNT, VERIFY, LOCKED};
  - function rotr8(logic [7:0], logic [2:0]);
  - localparam BYTE_W = 8.
- Sub-module `sync_matcher` holds the 8 parallel rotation compares. It outputs `match` and `k` (lowest matching k wins, for robustness only).

## Test plan
- Lock, defaults: send frames whose sync slot is rotl(8'hA5,3)=8'h2D and whose payload is rotated left by 3, continuous valid. Required: `locked`=1 after the third sync. The first forwarded word is payload index 1 of frame 3, with `sh_amt`=3. `barrel_shifter` output equals the original payload.
- False candidate: send a payload 8'hD2 while in HUNT, followed by a non-sync word at the expected slot. Required: back to HUNT, `locked` never asserts, nothing forwarded.
- Unlock: after lock, corrupt 3 sync slots then send a good one. Required: still locked, miss_cnt=0. Then corrupt 4 consecutive sync slots. Required: `locked` falls one cycle after the 4th bad slot is accepted.
- Backpressure: hold out_ready=0 for 5 cycles mid-frame. Required:
  - `in_ready`=0.
  - `out_data`/`sh_amt` stable.
  - fidx frozen.
  - No word lost or duplicated after release.
- Reset mid-frame: with LOCKED and out_valid=1, pulse `rst` for 1 cycle. Required: next cycle `out_valid`=0, `locked`=0, `sh_amt`=0, and the block relocks on 3 fresh frames.
- LOCK_COUNT=1, rotation 0: a single 8'hA5 is received. Required: `locked`=1 and `sh_amt`=0 on the following payload.

Source files
------------

// File: rtl/rotation_aligner_pkg.sv
// Shared types and helpers for the rotation aligner: FSM states, byte width and
// the rotate-right function used by both the matcher and the lock check.
package rotation_aligner_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  // rotr8(x, k) = {x[k-1:0], x[7:k]}
  function automatic logic [BYTE_W-1:0] rotr8(logic [BYTE_W-1:0] x, logic [2:0] k);
    logic [2*BYTE_W-1:0] w;
    w = {x, x} >> k;
    return w[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/rotation_aligner_sync_matcher.sv
// Eight parallel rotate-and-compare units; reports whether any rotation of the
// input equals the sync word, and the lowest matching rotation amount.
module sync_matcher
  import rotation_aligner_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_WORD = 8'hA5
) (
  input  logic [BYTE_W-1:0] data,
  output logic              match,
  output logic [2:0]        k
);

  always_comb begin
    match = 1'b0;
    k     = 3'd0;
    // Walk downwards so the lowest matching rotation is the one left standing.
    for (int i = 7; i >= 0; i--) begin
      if (rotr8(data, 3'(i)) == SYNC_WORD) begin
        match = 1'b1;
        k     = 3'(i);
      end
    end
  end

endmodule

// File: rtl/rotation_aligner.sv
// Hunts for the rotated sync word at frame boundaries, locks the rotation after
// repeated hits, and forwards payload words paired with the locked rotate amount.
module rotation_aligner
  import rotation_aligner_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_WORD    = 8'hA5,
  parameter int unsigned       FRAME_LEN    = 16,
  parameter int unsigned       LOCK_COUNT   = 3,
  parameter int unsigned       UNLOCK_COUNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic [2:0]        sh_amt,
  output logic              locked,
  output logic              sync_hit
);

  localparam int unsigned FW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned HW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MW = $clog2(UNLOCK_COUNT + 1);

  state_t          state;
  logic [FW-1:0]   fidx;
  logic [HW-1:0]   hit_cnt;
  logic [MW-1:0]   miss_cnt;
  logic [2:0]      k_cand;
  logic [2:0]      k_lock;

  logic            match;
  logic [2:0]      k;
  logic            accept;
  logic            slot0;
  logic            cand_hit;
  logic            lock_hit;
  logic            load;
  logic [FW-1:0]   fidx_next;

  sync_matcher #(
    .SYNC_WORD(SYNC_WORD)
  ) u_matcher (
    .data (in_data),
    .match(match),
    .k    (k)
  );

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign slot0     = (fidx == '0);
  assign cand_hit  = (rotr8(in_data, k_cand) == SYNC_WORD);
  assign lock_hit  = (rotr8(in_data, k_lock) == SYNC_WORD);
  assign load      = accept && (state == LOCKED) && !slot0;
  assign fidx_next = (fidx == FW'(FRAME_LEN - 1)) ? '0 : fidx + FW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      fidx      <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      k_cand    <= 3'd0;
      k_lock    <= 3'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sh_amt    <= 3'd0;
      locked    <= 1'b0;
      sync_hit  <= 1'b0;
    end else begin
      sync_hit <= 1'b0;

      // A new load replaces a word being drained in the same cycle, so no bubble.
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
        sh_amt    <= k_lock;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        fidx <= fidx_next;
        unique case (state)
          HUNT: begin
            if (match) begin
              k_cand   <= k;
              hit_cnt  <= HW'(1);
              fidx     <= FW'(1);
              sync_hit <= 1'b1;
              if (LOCK_COUNT == 1) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                k_lock   <= k;
                miss_cnt <= '0;
              end else begin
                state <= VERIFY;
              end
            end else begin
              fidx <= '0;
            end
          end
          VERIFY: begin
            if (slot0) begin
              if (cand_hit) begin
                sync_hit <= 1'b1;
                hit_cnt  <= hit_cnt + HW'(1);
                if (hit_cnt + HW'(1) == HW'(LOCK_COUNT)) begin
                  state    <= LOCKED;
                  locked   <= 1'b1;
                  k_lock   <= k_cand;
                  miss_cnt <= '0;
                end
              end else begin
                state   <= HUNT;
                hit_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (slot0) begin
              if (lock_hit) begin
                sync_hit <= 1'b1;
                miss_cnt <= '0;
              end else if (miss_cnt + MW'(1) == MW'(UNLOCK_COUNT)) begin
                state    <= HUNT;
                locked   <= 1'b0;
                miss_cnt <= '0;
                hit_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + MW'(1);
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rotation_aligner.sv
// Randomized frame stimulus against a frame-level reference model; a scoreboard
// restores each forwarded word with its sh_amt and compares to the plaintext.
module tb_rotation_aligner;

  localparam int FL = 16;
  localparam int LC = 3;
  localparam int UC = 4;
  localparam logic [7:0] SW = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, locked, sync_hit;
  logic [7:0] in_data, out_data;
  logic [2:0] sh_amt;

  logic       v1, rdy1, ir1, ov1, lk1, sh1;
  logic [7:0] d1, od1;
  logic [2:0] sa1;

  always #5 clk = ~clk;

  rotation_aligner u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sh_amt(sh_amt),
    .locked(locked), .sync_hit(sync_hit)
  );

  rotation_aligner #(.LOCK_COUNT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_data(d1),
    .out_valid(ov1), .out_ready(rdy1), .out_data(od1), .sh_amt(sa1),
    .locked(lk1), .sync_hit(sh1)
  );

  int errors = 0;
  int checks = 0;
  int vld_pct = 100;
  int rdy_pct = 100;

  // Reference model state: 0 hunting, 1 verifying, 2 locked.
  int         m_state, m_fidx, m_hit, m_miss, m_kc, m_kl, m_sh;
  bit         m_ov, m_locked, m_sync;
  logic [7:0] m_od;
  logic [7:0] sbq[$];

  function automatic logic [7:0] rotr(input logic [7:0] x, input int k);
    int t;
    t = x;
    t = (t >> k) | (t << (8 - k));
    return t[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
    return rotr(x, (8 - k) % 8);
  endfunction

  function automatic int first_k(input logic [7:0] x);
    for (int k = 0; k < 8; k++) if (rotr(x, k) == SW) return k;
    return -1;
  endfunction

  function automatic logic [7:0] rand_payload();
    logic [7:0] p;
    do p = 8'($urandom); while (first_k(p) >= 0);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=none expected=event", tag);
  endtask

  task automatic model_reset();
    m_state = 0; m_fidx = 0; m_hit = 0; m_miss = 0; m_kc = 0; m_kl = 0;
    m_ov = 0; m_od = 8'h00; m_sh = 0; m_locked = 0; m_sync = 0;
    sbq.delete();
  endtask

  task automatic model_update(input bit acc, input logic [7:0] d, input bit rdy,
                              input logic [7:0] orig);
    bit ld;
    int kk;
    ld = 0;
    m_sync = 0;
    if (acc) begin
      if (m_state == 0) begin
        kk = first_k(d);
        if (kk >= 0) begin
          m_kc = kk; m_hit = 1; m_fidx = 1; m_sync = 1;
          if (LC == 1) begin m_state = 2; m_kl = kk; m_miss = 0; end
          else m_state = 1;
        end else m_fidx = 0;
      end else begin
        if (m_state == 1 && m_fidx == 0) begin
          if (rotr(d, m_kc) == SW) begin
            m_hit++; m_sync = 1;
            if (m_hit == LC) begin m_state = 2; m_kl = m_kc; m_miss = 0; end
          end else begin
            m_state = 0; m_hit = 0;
          end
        end else if (m_state == 2) begin
          if (m_fidx != 0) begin
            ld = 1; m_od = d; m_sh = m_kl; sbq.push_back(orig);
          end else if (rotr(d, m_kl) == SW) begin
            m_miss = 0; m_sync = 1;
          end else begin
            m_miss++;
            if (m_miss == UC) begin m_state = 0; m_miss = 0; m_hit = 0; end
          end
        end
        m_fidx = (m_fidx + 1) % FL;
      end
    end
    if (ld) m_ov = 1;
    else if (rdy) m_ov = 0;
    m_locked = (m_state == 2);
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit rdy, input logic [7:0] orig,
                      output bit acc);
    logic [7:0] exp_w;
    bit exp_ready;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = rdy;
    #1;
    exp_ready = !m_ov || rdy;
    chk("in_ready", in_ready, exp_ready);
    if (m_ov && rdy) begin
      if (sbq.size() == 0) fail_now("sb_underflow");
      else begin
        exp_w = sbq.pop_front();
        chk("restored", rotr(out_data, int'(sh_amt)), exp_w);
      end
    end
    acc = v && exp_ready;
    model_update(acc, d, rdy, orig);
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("sh_amt", sh_amt, m_sh);
    chk("locked", locked, m_locked);
    chk("sync_hit", sync_hit, m_sync);
  endtask

  task automatic send_word(input logic [7:0] d, input logic [7:0] orig);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 64) begin
      step(($urandom % 100) < vld_pct, d, ($urandom % 100) < rdy_pct, orig, acc);
      tries++;
    end
    if (!acc) fail_now("accept_timeout");
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1; in_valid = 0; out_ready = 1; v1 = 0; rdy1 = 1;
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sh_amt", sh_amt, 0);
    chk("rst_locked", locked, 0);
    chk("rst_sync_hit", sync_hit, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0;
  endtask

  // stall_at: hold out_ready low for 5 cycles before that slot; rst_at: reset there.
  task automatic send_frame(input int rot, input bit good, input int stall_at, input int rst_at);
    logic [7:0] p;
    bit acc;
    send_word(good ? rotl(SW, rot) : 8'h00, 8'h00);
    for (int i = 1; i < FL; i++) begin
      if (i == rst_at) begin
        chk("pre_rst_out_valid", out_valid, 1);
        do_reset(1);
        return;
      end
      p = rand_payload();
      if (i == stall_at) begin
        for (int s = 0; s < 5; s++) begin
          step(1'b1, rotl(p, rot), 1'b0, p, acc);
          if (acc) fail_now("stall_accepted");
        end
      end
      send_word(rotl(p, rot), p);
    end
  endtask

  bit acc_d;

  initial begin
    rst = 1; in_valid = 0; in_data = 0; out_ready = 1; v1 = 0; d1 = 0; rdy1 = 1;
    do_reset(2);

    // Lock with defaults, rotation 3, continuous valid.
    for (int f = 0; f < 5; f++) send_frame(3, 1'b1, -1, -1);

    // False candidate: one rotated sync byte in payload, then a bad sync slot.
    do_reset(1);
    step(1'b1, 8'hD2, 1'b1, 8'h00, acc_d);
    for (int i = 1; i < FL; i++) step(1'b1, rand_payload(), 1'b1, 8'h00, acc_d);
    step(1'b1, 8'h00, 1'b1, 8'h00, acc_d);
    for (int i = 0; i < 2 * FL; i++) step(1'b1, rand_payload(), 1'b1, 8'h00, acc_d);

    // Unlock behaviour with random gaps and backpressure.
    do_reset(1);
    vld_pct = 85;
    rdy_pct = 75;
    for (int f = 0; f < 3; f++) send_frame(5, 1'b1, -1, -1);
    send_frame(5, 1'b1, 5, -1);
    for (int f = 0; f < 3; f++) send_frame(5, 1'b0, -1, -1);
    send_frame(5, 1'b1, -1, -1);
    chk("miss_cnt_clear", u0.miss_cnt, 0);
    for (int f = 0; f < 4; f++) send_frame(5, 1'b0, -1, -1);
    for (int f = 0; f < 4; f++) send_frame(5, 1'b1, -1, -1);

    // Reset mid-frame while a word is held, then relock on a new rotation.
    send_frame(5, 1'b1, -1, 6);
    for (int f = 0; f < 4; f++) send_frame(6, 1'b1, -1, -1);

    // Single-hit lock at rotation 0.
    do_reset(1);
    @(negedge clk);
    v1 = 1; d1 = SW; rdy1 = 1;
    @(posedge clk);
    #1;
    chk("lc1_locked", lk1, 1);
    chk("lc1_sync_hit", sh1, 1);
    chk("lc1_no_fwd", ov1, 0);
    @(negedge clk);
    d1 = 8'h3C;
    @(posedge clk);
    #1;
    chk("lc1_out_valid", ov1, 1);
    chk("lc1_out_data", od1, 8'h3C);
    chk("lc1_sh_amt", sa1, 0);
    @(negedge clk);
    v1 = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
